wb_dmx_tx: RTL and testbench

Wishbone slave DMX512 transmitter for the LM32 SoC, mapped on a conbus slave port beside uart0/spi0/pwm0. Firmware fills a 512-byte slot buffer and sets frame parameters. The block autonomously generates complete DMX512 frames (BREAK, MAB, start code, slots) on an RS-485 line driver, either one-shot or continuously.

---
 rtl/dmx_pkg.sv | 27 ++
 rtl/dmx_tx_shift.sv | 44 ++++
 rtl/wb_dmx_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_wb_dmx_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// Shared definitions for the DMX512 transmitter: FSM states, register map, bit indices.
package dmx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_BREAK, ST_MAB, ST_START, ST_SLOT, ST_MBB
    } dmx_state_t;

    localparam logic [9:0] DMX_CTRL   = 10'h200;
    localparam logic [9:0] DMX_STATUS = 10'h204;
    localparam logic [9:0] DMX_SLOTS  = 10'h208;

    localparam int DMX_MAX_SLOTS = 512;

    localparam int CTRL_GO      = 0;
    localparam int CTRL_CONT    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_SC_LSB  = 8;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_IDX_LSB = 9;

    // A count of zero or anything past the universe size means a full universe.
    function automatic logic [9:0] clamp_slots(input logic [9:0] n);
        return (n == 10'd0 || n > 10'(DMX_MAX_SLOTS)) ? 10'(DMX_MAX_SLOTS) : n;
    endfunction

endpackage

// File: rtl/dmx_tx_shift.sv
// 8N2 byte serializer: start bit, 8 data bits LSB first, two stop bits, BIT_CLKS clocks each.
module dmx_tx_shift #(
    parameter int BIT_CLKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic       ready,
    output logic       txd
);

    localparam int TW = $clog2(BIT_CLKS);
    localparam logic [TW-1:0] T_MAX = TW'(BIT_CLKS - 1);

    logic [10:0]   sr;
    logic [3:0]    bits_left;
    logic [TW-1:0] timer;

    // Ready in the last clock of the final stop bit so a new byte follows with no gap.
    assign ready = (bits_left == 4'd0) || (bits_left == 4'd1 && timer == '0);
    assign txd   = (bits_left == 4'd0) ? 1'b1 : sr[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr        <= '1;
            bits_left <= '0;
            timer     <= '0;
        end else if (load) begin
            sr        <= {2'b11, tx_byte, 1'b0};
            bits_left <= 4'd11;
            timer     <= T_MAX;
        end else if (bits_left != 4'd0) begin
            if (timer == '0) begin
                sr        <= {1'b1, sr[10:1]};
                bits_left <= bits_left - 4'd1;
                timer     <= T_MAX;
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_dmx_tx.sv
// Wishbone DMX512 transmitter: 512-slot buffer, frame FSM, 8N2 serializer.
// Optional frame-done interrupt under WB_DMX_TX_IRQ_EN.
module wb_dmx_tx
    import dmx_pkg::*;
#(
    parameter int clk_freq   = 100000000,
    parameter int baud       = 250000,
    parameter int break_bits = 44,
    parameter int mab_bits   = 4,
    parameter int mbb_bits   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        dmx_txd,
    output logic        dmx_de,
    output logic        intr
);

    localparam int BIT_CLKS   = clk_freq / baud;
    localparam int BREAK_CLKS = break_bits * BIT_CLKS;
    localparam int MAB_CLKS   = mab_bits * BIT_CLKS;
    localparam int MBB_CLKS   = mbb_bits * BIT_CLKS;
    localparam int MAX_CLKS   = (BREAK_CLKS > MAB_CLKS) ?
                                ((BREAK_CLKS > MBB_CLKS) ? BREAK_CLKS : MBB_CLKS) :
                                ((MAB_CLKS > MBB_CLKS) ? MAB_CLKS : MBB_CLKS);
    localparam int CW = $clog2(MAX_CLKS + 1);

    dmx_state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0] mem [0:127];
    logic [31:0] rd_q, csr_q, csr_rd;
    logic [6:0]  rd_addr;
    logic        rd_is_buf;
    logic        ctrl_cont, ctrl_irq, done, done_nxt;
    logic [7:0]  start_code, sc_lat, next_byte, sh_byte;
    logic [9:0]  slots_reg, slots_lat, cur_idx, fetch_idx;
    logic        fetch_req, fetch_rd, fetch_go;
    logic [1:0]  fetch_lane;
    logic        sh_load, sh_ready, sh_txd, last_slot, enter_break;
    logic        req, commit, wr_ctrl, wr_status, wr_slots, buf_wr, cpu_rd, go;
    logic        unused_adr;

    assign unused_adr = ^{wb_adr_i[31:10], wb_adr_i[1:0]};

    // Requests are acked one cycle later; writes take effect at the end of the ack cycle.
    assign req       = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign commit    = wb_stb_i & wb_cyc_i & wb_we_i & wb_ack_o;
    assign wr_ctrl   = commit & (wb_adr_i[9:2] == DMX_CTRL[9:2]);
    assign wr_status = commit & (wb_adr_i[9:2] == DMX_STATUS[9:2]);
    assign wr_slots  = commit & (wb_adr_i[9:2] == DMX_SLOTS[9:2]);
    assign buf_wr    = commit & ~wb_adr_i[9];
    assign cpu_rd    = req & ~wb_we_i & ~wb_adr_i[9];
    assign go        = wr_ctrl & wb_dat_i[CTRL_GO];

    // Slot buffer: CPU owns the read port when it wants it; the fetch waits a cycle.
    assign fetch_go = fetch_req & ~cpu_rd;
    assign rd_addr  = cpu_rd ? wb_adr_i[8:2] : fetch_idx[8:2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (buf_wr && wb_sel_i[i]) mem[wb_adr_i[8:2]][8*i +: 8] <= wb_dat_i[8*i +: 8];
        rd_q <= mem[rd_addr];
    end

    always_comb begin
        csr_rd = '0;
        case (wb_adr_i[9:2])
            DMX_CTRL[9:2]:   csr_rd = {16'h0, start_code, 5'h0, ctrl_irq, ctrl_cont, 1'b0};
            DMX_STATUS[9:2]: csr_rd = {13'h0, cur_idx, 7'h0, done, state != ST_IDLE};
            DMX_SLOTS[9:2]:  csr_rd = {22'h0, slots_reg};
            default:         csr_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_ack_o  <= 1'b0;
            csr_q     <= '0;
            rd_is_buf <= 1'b0;
        end else begin
            wb_ack_o <= req;
            if (req) begin
                csr_q     <= csr_rd;
                rd_is_buf <= ~wb_adr_i[9];
            end
        end
    end

    assign wb_dat_o = wb_ack_o ? (rd_is_buf ? rd_q : csr_q) : 32'h0;

    // DONE set on MBB completion beats a same-cycle clear.
    assign done_nxt = (state == ST_MBB && cnt == '0) ? 1'b1 :
                      (wr_status && wb_dat_i[STAT_DONE]) ? 1'b0 : done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_cont  <= 1'b0;
            start_code <= '0;
            slots_reg  <= 10'(DMX_MAX_SLOTS);
            done       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_cont  <= wb_dat_i[CTRL_CONT];
                start_code <= wb_dat_i[CTRL_SC_LSB +: 8];
            end
            if (wr_slots) slots_reg <= clamp_slots(wb_dat_i[9:0]);
            done <= done_nxt;
        end
    end

`ifdef WB_DMX_TX_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_irq <= 1'b0;
            intr     <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_irq <= wb_dat_i[CTRL_IRQ_EN];
            intr <= done_nxt & ctrl_irq;
        end
    end
`else
    assign ctrl_irq = 1'b0;
    assign intr     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    assign last_slot = (cur_idx == slots_lat - 10'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (go) state_nxt = ST_BREAK;
            ST_BREAK: if (cnt == '0) state_nxt = ST_MAB;
            ST_MAB:   if (cnt == '0) state_nxt = ST_START;
            ST_START: if (sh_ready) state_nxt = ST_SLOT;
            ST_SLOT:  if (sh_ready && last_slot) state_nxt = ST_MBB;
            ST_MBB:   if (cnt == '0) state_nxt = ctrl_cont ? ST_BREAK : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The start code is loaded in the last MAB clock so its start bit opens START.
    always_comb begin
        sh_load = 1'b0;
        sh_byte = next_byte;
        dmx_de  = (state != ST_IDLE);
        dmx_txd = sh_txd;
        case (state)
            ST_BREAK: dmx_txd = 1'b0;
            ST_MAB: if (cnt == '0) begin
                sh_load = 1'b1;
                sh_byte = sc_lat;
            end
            ST_START: sh_load = sh_ready;
            ST_SLOT:  sh_load = sh_ready & ~last_slot;
            default:  ;
        endcase
    end

    function automatic logic [CW-1:0] dur(input dmx_state_t s);
        case (s)
            ST_BREAK: return CW'(BREAK_CLKS - 1);
            ST_MAB:   return CW'(MAB_CLKS - 1);
            ST_MBB:   return CW'(MBB_CLKS - 1);
            default:  return '0;
        endcase
    endfunction

    assign enter_break = (state_nxt == ST_BREAK) && (state != ST_BREAK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            slots_lat  <= 10'(DMX_MAX_SLOTS);
            sc_lat     <= '0;
            cur_idx    <= '0;
            fetch_idx  <= '0;
            fetch_req  <= 1'b0;
            fetch_rd   <= 1'b0;
            fetch_lane <= '0;
            next_byte  <= '0;
        end else begin
            if (state_nxt != state) cnt <= dur(state_nxt);
            else if (cnt != '0)     cnt <= cnt - 1'b1;
            fetch_rd <= fetch_go;
            if (fetch_go) begin
                fetch_req  <= 1'b0;
                fetch_lane <= fetch_idx[1:0];
            end
            if (fetch_rd) next_byte <= rd_q[8*fetch_lane +: 8];
            // Frame parameters freeze here; a GO write carries its own start code/count.
            if (enter_break) begin
                slots_lat <= wr_slots ? clamp_slots(wb_dat_i[9:0]) : slots_reg;
                sc_lat    <= wr_ctrl ? wb_dat_i[CTRL_SC_LSB +: 8] : start_code;
                fetch_idx <= '0;
                fetch_req <= 1'b1;
            end
            if (state == ST_START && sh_ready)     cur_idx <= '0;
            else if (state == ST_SLOT && sh_load)  cur_idx <= cur_idx + 10'd1;
            if (sh_load && state != ST_MAB) begin
                fetch_idx <= fetch_idx + 10'd1;
                fetch_req <= 1'b1;
            end
        end
    end

    dmx_tx_shift #(.BIT_CLKS(BIT_CLKS)) u_shift (
        .clk     (clk),
        .reset   (reset),
        .load    (sh_load),
        .tx_byte (sh_byte),
        .ready   (sh_ready),
        .txd     (sh_txd)
    );

endmodule

// File: tb/tb_wb_dmx_tx.sv
// Directed/randomized bench for wb_dmx_tx: txd/de waveform compared against a bit-list frame model.
module tb_wb_dmx_tx;

    localparam int BC  = 4;
    localparam int BRK = 44;
    localparam int MAB = 4;
    localparam int MBB = 4;
    localparam logic [31:0] A_CTRL = 32'h200, A_STAT = 32'h204, A_SLOTS = 32'h208;

    logic clk = 1'b0, reset = 1'b0;
    logic [31:0] adr = '0, dat = '0, dat_o;
    logic [3:0]  sel = '0;
    logic stb = 1'b0, cyc = 1'b0, we = 1'b0, ack, txd, de, intr;

    int errors = 0, checks = 0;
    logic [7:0] mem_m [0:511];
    logic q_txd[$], q_de[$], e_txd[$], e_de[$];
    logic cap = 1'b0, ack_txd;

    always #5 clk = ~clk;

    wb_dmx_tx #(.clk_freq(1000000), .baud(250000), .break_bits(BRK), .mab_bits(MAB), .mbb_bits(MBB)) dut (
        .clk(clk), .reset(reset), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o), .wb_sel_i(sel),
        .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we), .wb_ack_o(ack),
        .dmx_txd(txd), .dmx_de(de), .intr(intr)
    );

    always begin
        @(posedge clk); #2;
        if (cap) begin q_txd.push_back(txd); q_de.push_back(de); end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        int n = 0;
        adr = a; dat = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
        do begin @(posedge clk); #1; n++; end while (ack !== 1'b1 && n < 20);
        if (ack !== 1'b1) check("ack_timeout", ack, 1);
        r = dat_o;
        ack_txd = txd;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_xfer(1'b1, a, d, 4'hF, r);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        wb_xfer(1'b0, a, 32'h0, 4'hF, r);
    endtask

    task automatic buf_write(input int w, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb_xfer(1'b1, 32'(w * 4), d, s, r);
        for (int i = 0; i < 4; i++) if (s[i]) mem_m[w*4+i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_word(input int w);
        return {mem_m[w*4+3], mem_m[w*4+2], mem_m[w*4+1], mem_m[w*4]};
    endfunction

    task automatic exp_bits(input logic v, input logic d, input int n);
        repeat (n) begin e_txd.push_back(v); e_de.push_back(d); end
    endtask

    task automatic exp_byte(input logic [7:0] b);
        logic [10:0] f;
        f = {2'b11, b, 1'b0};
        for (int i = 0; i < 11; i++) exp_bits(f[i], 1'b1, BC);
    endtask

    task automatic exp_frame(input logic [7:0] sc, input int n);
        exp_bits(1'b0, 1'b1, BRK * BC);
        exp_bits(1'b1, 1'b1, MAB * BC);
        exp_byte(sc);
        for (int i = 0; i < n; i++) exp_byte(mem_m[i]);
        exp_bits(1'b1, 1'b1, MBB * BC);
    endtask

    task automatic clear_wave;
        q_txd.delete(); q_de.delete(); e_txd.delete(); e_de.delete();
    endtask

    task automatic wait_samples(input int n);
        int g = 0;
        while (q_txd.size() < n && g < 20000) begin @(posedge clk); #1; g++; end
        if (q_txd.size() < n) check("sample_timeout", 32'(q_txd.size()), 32'(n));
    endtask

    task automatic cmp_wave(input string tag);
        int bad = -1;
        if (q_txd.size() < e_txd.size()) bad = q_txd.size();
        else
            for (int i = 0; i < e_txd.size(); i++)
                if (q_txd[i] !== e_txd[i] || q_de[i] !== e_de[i]) begin bad = i; break; end
        if (bad >= 0 && bad < q_txd.size())
            $display("  %s first bad sample %0d: txd=%b de=%b want txd=%b de=%b",
                     tag, bad, q_txd[bad], q_de[bad], e_txd[bad], e_de[bad]);
        check(tag, 32'(bad), 32'hFFFF_FFFF);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  sc;
        int n, n1, n2, w, l1;
        logic [31:0] d;
        logic [3:0]  s;

        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd, 1); check("rst_de", de, 0); check("rst_intr", intr, 0);
        check("rst_ack", ack, 0); check("rst_dat", dat_o, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        rd(A_CTRL, r);  check("rst_ctrl", r, 0);
        rd(A_STAT, r);  check("rst_status", r, 0);
        rd(A_SLOTS, r); check("rst_slots", r, 512);
        check("ack_one_cycle", ack, 0);

        // Single frame 00,11,22,33,44 with a GO rewrite in the middle of the slots.
        buf_write(0, 32'h44332211, 4'hF);
        wr(A_SLOTS, 4);
        rd(A_SLOTS, r); check("slots_rb", r, 4);
        clear_wave();
        exp_frame(8'h00, 4);
        exp_bits(1'b1, 1'b0, 8);
        wr(A_CTRL, 32'h0001);
        cap = 1'b1;
        check("go_ack_txd", ack_txd, 1);
        check("go_txd_fall", {txd, de}, 2'b01);
        wait_samples(296);
        wr(A_CTRL, 32'h0001);
        wait_samples(e_txd.size());
        cap = 1'b0;
        cmp_wave("frame1_wave");
        rd(A_STAT, r); check("frame1_done_idle", r[1:0], 2'b10);
        check("no_irq_en_intr", intr, 0);
        wr(A_STAT, 32'h2);
        rd(A_STAT, r); check("w1c_done", r[1:0], 2'b00);

        // Slot count clamp.
        wr(A_SLOTS, 0);   rd(A_SLOTS, r); check("slots_zero", r, 512);
        wr(A_SLOTS, 600); rd(A_SLOTS, r); check("slots_600", r, 512);
        n = $urandom_range(1, 512);
        wr(A_SLOTS, n);   rd(A_SLOTS, r); check("slots_rand", r, 32'(n));

        // Buffer readback with random byte lanes.
        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(8, 127);
            d = $urandom; s = 4'($urandom_range(1, 15));
            buf_write(w, $urandom, 4'hF);
            buf_write(w, d, s);
            rd(32'(w * 4), r);
            check("buf_rb", r, model_word(w));
        end

        // Random frame with IRQ_EN set.
        n = $urandom_range(1, 8);
        for (int k = 0; k < 2; k++) buf_write(k, $urandom, 4'hF);
        sc = 8'($urandom);
        wr(A_SLOTS, n);
        clear_wave();
        exp_frame(sc, n);
        exp_bits(1'b1, 1'b0, 8);
        wr(A_CTRL, {16'h0, sc, 8'h05});
        cap = 1'b1;
        wait_samples(e_txd.size());
        cap = 1'b0;
        cmp_wave("rand_frame_wave");
        rd(A_CTRL, r);
`ifdef WB_DMX_TX_IRQ_EN
        check("ctrl_rb", r, {16'h0, sc, 8'h04});
        check("intr_set", intr, 1);
`else
        check("ctrl_rb", r, {16'h0, sc, 8'h00});
        check("intr_tied", intr, 0);
`endif
        wr(A_STAT, 32'h2);
        check("intr_clr", intr, 0);
        rd(A_STAT, r); check("w1c_done2", r[1:0], 2'b00);

        // Continuous: SLOTS change mid frame 1, buffer read mid frame 1, CONT cleared in frame 2.
        for (int k = 0; k < 4; k++) buf_write(k, $urandom, 4'hF);
        n1 = $urandom_range(1, 4);
        n2 = $urandom_range(5, 12);
        l1 = (BRK + MAB + 11 * (n1 + 1) + MBB) * BC;
        wr(A_SLOTS, n1);
        clear_wave();
        exp_frame(8'h55, n1);
        exp_frame(8'h55, n2);
        exp_bits(1'b1, 1'b0, 8);
        wr(A_CTRL, 32'h5503);
        cap = 1'b1;
        wait_samples(60);
        wr(A_SLOTS, n2);
        w = $urandom_range(8, 127);
        buf_write(w, $urandom, 4'hF);
        rd(32'(w * 4), r); check("buf_rb_busy", r, model_word(w));
        wait_samples(l1 + 100);
        wr(A_CTRL, 32'h5500);
        wait_samples(e_txd.size());
        cap = 1'b0;
        cmp_wave("cont_wave");
        rd(A_STAT, r); check("cont_idle", r[1:0], 2'b10);

        // Reset in the middle of slot 2.
        wr(A_SLOTS, 4);
        clear_wave();
        wr(A_CTRL, 32'h7702);
        wr(A_CTRL, 32'h7703);
        cap = 1'b1;
        wait_samples(334);
        check("pre_reset_busy", de, 1);
        reset = 1'b0;
        #1;
        check("async_rst_txd", txd, 1);
        check("async_rst_de", de, 0);
        cap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        rd(A_CTRL, r);  check("post_rst_ctrl", r, 0);
        rd(A_STAT, r);  check("post_rst_status", r, 0);
        rd(A_SLOTS, r); check("post_rst_slots", r, 512);
        check("post_rst_lines", {txd, de, intr}, 3'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
